// File: rtl/regfile_operand_stage.sv
// Register-read / operand-issue stage: 32x32 register file with write-through bypass,
// feeding a single registered operand slot under a valid/ready handshake.
module regfile_operand_stage #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [4:0]            ctrl_ALUopcode_in,
  input  logic [4:0]            ctrl_shiftamt_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_operandA,
  output logic [DATA_WIDTH-1:0] data_operandB,
  output logic [4:0]            ctrl_ALUopcode,
  output logic [4:0]            ctrl_shiftamt
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]            alu_q, alu_d, sh_q, sh_d;
  logic [ADDR_WIDTH-1:0] rsa_q, rsa_d, rsb_q, rsb_d;
  logic                  accept, consume, wr_nz;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = vld_q && out_ready;
  assign wr_nz    = ctrl_writeEnable && (ctrl_writeReg != '0);

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0]               r,
    input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf,
    input logic                                we,
    input logic [ADDR_WIDTH-1:0]               wr,
    input logic [DATA_WIDTH-1:0]               wd
  );
    if (r == '0)                 return '0;
    else if (we && (wr == r))    return wd;
    else                         return rf[r];
  endfunction

  always_comb begin
    vld_d = vld_q;
    opa_d = opa_q;
    opb_d = opb_q;
    alu_d = alu_q;
    sh_d  = sh_q;
    rsa_d = rsa_q;
    rsb_d = rsb_q;
    if (accept) begin
      vld_d = 1'b1;
      opa_d = rd_port(ctrl_readRegA, regs_q, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      opb_d = rd_port(ctrl_readRegB, regs_q, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      alu_d = ctrl_ALUopcode_in;
      sh_d  = ctrl_shiftamt_in;
      rsa_d = ctrl_readRegA;
      rsb_d = ctrl_readRegB;
    end else if (consume) begin
      vld_d = 1'b0;
    end else if (vld_q) begin
      // A held slot tracks writeback so it never issues a stale operand.
      if (wr_nz && (ctrl_writeReg == rsa_q)) opa_d = data_writeReg;
      if (wr_nz && (ctrl_writeReg == rsb_q)) opb_d = data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      regs_q <= '0;
    end else if (wr_nz) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      vld_q <= 1'b0;
      opa_q <= '0;
      opb_q <= '0;
      alu_q <= '0;
      sh_q  <= '0;
      rsa_q <= '0;
      rsb_q <= '0;
    end else begin
      vld_q <= vld_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      alu_q <= alu_d;
      sh_q  <= sh_d;
      rsa_q <= rsa_d;
      rsb_q <= rsb_d;
    end
  end

  assign out_valid      = vld_q;
  assign data_operandA  = opa_q;
  assign data_operandB  = opb_q;
  assign ctrl_ALUopcode = alu_q;
  assign ctrl_shiftamt  = sh_q;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Scoreboard bench: queued instructions are checked against an architectural register model
// whenever the slot is presented; a full slot must always show the current value of its sources.
module tb_regfile_operand_stage;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        in_valid, in_ready;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB, ctrl_ALUopcode_in, ctrl_shiftamt_in;
  logic        out_valid, out_ready;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;

  regfile_operand_stage dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .ctrl_ALUopcode_in(ctrl_ALUopcode_in), .ctrl_shiftamt_in(ctrl_shiftamt_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] ra, rb, op, sh; } slot_t;

  logic [31:0] mregs [32];
  slot_t       q [$];
  bit          mvld;
  int          vec = 0, err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mvld = 0;
    q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  // Reference: one slot, architectural registers, writes visible to a held slot.
  always @(posedge clock) begin
    bit acc, cons;
    if (!ctrl_reset_n) begin
      model_clear();
    end else begin
      acc  = in_valid && (!mvld || out_ready);
      cons = mvld && out_ready;
      if (cons && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{ctrl_readRegA, ctrl_readRegB, ctrl_ALUopcode_in, ctrl_shiftamt_in});
      mvld = acc || (mvld && !out_ready);
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) mregs[ctrl_writeReg] = data_writeReg;
    end
  end

  // The slot must present the registers' current contents (writes up to the last edge).
  always @(negedge clock) begin
    slot_t s;
    if (ctrl_reset_n) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, mvld});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!mvld || out_ready)});
      if (mvld) begin
        if (q.size() == 0) begin
          vec++; err++;
          $display("FAIL scoreboard_empty: got slot full want expected entry at %0t", $time);
        end else begin
          s = q[0];
          chk("operandA", data_operandA, (s.ra == 0) ? 32'h0 : mregs[s.ra]);
          chk("operandB", data_operandB, (s.rb == 0) ? 32'h0 : mregs[s.rb]);
          chk("opcode", {27'b0, ctrl_ALUopcode}, {27'b0, s.op});
          chk("shamt", {27'b0, ctrl_shiftamt}, {27'b0, s.sh});
        end
      end
    end
  end

  task automatic drv(input bit we, input logic [4:0] wr, input logic [31:0] wd, input bit iv,
                     input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] op,
                     input logic [4:0] sh, input bit ordy);
    ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    in_valid = iv; ctrl_readRegA = ra; ctrl_readRegB = rb;
    ctrl_ALUopcode_in = op; ctrl_shiftamt_in = sh; out_ready = ordy;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
    in_valid = 0; ctrl_readRegA = 0; ctrl_readRegB = 0;
    ctrl_ALUopcode_in = 0; ctrl_shiftamt_in = 0; out_ready = 0;
  endtask

  task automatic chk_zero_slot(input string nm);
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'h0);
    chk({nm, "_opA"}, data_operandA, 32'h0);
    chk({nm, "_opB"}, data_operandB, 32'h0);
    chk({nm, "_opc"}, {27'b0, ctrl_ALUopcode}, 32'h0);
    chk({nm, "_sh"}, {27'b0, ctrl_shiftamt}, 32'h0);
  endtask

  initial begin
    model_clear();
    idle();
    ctrl_reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_zero_slot("reset");
    ctrl_reset_n = 1;

    // reset then read
    drv(0, 0, 0, 1, 5, 9, 5'd0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // write then read
    drv(1, 3, 32'h0000_1234, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 3, 0, 5'd1, 5'd7, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // bypass
    drv(1, 7, 32'hDEAD_BEEF, 1, 7, 7, 5'd2, 5'd1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // r0 immutable
    drv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 5'd3, 5'd2, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // stall + refresh
    drv(1, 4, 32'h1, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 4, 4, 5'd9, 5'd3, 0);
    drv(1, 4, 32'h55, 1, 1, 2, 5'd10, 0, 0);
    drv(0, 0, 0, 1, 1, 2, 5'd10, 0, 0);
    drv(1, 4, 32'h66, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // randomized traffic over a small index range so collisions are frequent
    for (int i = 0; i < 1500; i++)
      drv($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 2) != 0);

    // back-to-back, then async reset mid-slot
    for (int i = 0; i < 4; i++)
      drv(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(10 + i), 5'(9 + i), 5'(i), 5'(i + 1), 1);
    idle();
    @(negedge clock); #2;
    ctrl_reset_n = 0;
    #1;
    chk_zero_slot("async_reset");
    model_clear();
    #1;
    ctrl_reset_n = 1;
    @(posedge clock); #1;
    for (int r = 1; r < 32; r += 2)
      drv(0, 0, 0, 1, 5'(r), 5'(r + 1), 5'd4, 5'd4, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
